// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// mem_ctrl : sequences READ/WRITE/FILL/COPY requests onto a single-port memory
// Rev 1.0 - initial release
// ============================================================================
module mem_ctrl #(
  parameter int DATA_W = 44,
  parameter int ADDR_W = 44,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [8:0]        req_len,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_out
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_WR    = 3'd2;
  localparam logic [2:0] S_FILL  = 3'd3;
  localparam logic [2:0] S_CP_RD = 3'd4;
  localparam logic [2:0] S_CP_WR = 3'd5;
  localparam logic [2:0] S_RESP  = 3'd6;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q, hold;
  logic [8:0]        len_q, cnt;
  logic              accept, range_ok, last_word;
  logic [ADDR_W:0]   src_end, dst_end;
  logic [ADDR_W-1:0] cnt_x;

  assign accept    = req_valid && req_ready;
  assign src_end   = {1'b0, req_addr} + (ADDR_W+1)'(req_len);
  assign dst_end   = {1'b0, req_data[ADDR_W-1:0]} + (ADDR_W+1)'(req_len);
  assign last_word = (cnt == len_q - 9'd1);
  assign cnt_x     = ADDR_W'(cnt);

  // Range check uses one extra bit so base+len cannot wrap past the limit.
  always_comb begin
    range_ok = 1'b0;
    case (req_op)
      OP_READ, OP_WRITE: range_ok = ({1'b0, req_addr} < LIMIT);
      OP_FILL:           range_ok = (src_end <= LIMIT);
      default:           range_ok = (src_end <= LIMIT) && (dst_end <= LIMIT);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!range_ok) state_nxt = S_RESP;
          else begin
            case (req_op)
              OP_READ:  state_nxt = S_RD;
              OP_WRITE: state_nxt = S_WR;
              OP_FILL:  state_nxt = (req_len == 9'd0) ? S_RESP : S_FILL;
              default:  state_nxt = (req_len == 9'd0) ? S_RESP : S_CP_RD;
            endcase
          end
        end
      end
      S_RD, S_WR: state_nxt = S_RESP;
      S_FILL:     state_nxt = last_word ? S_RESP : S_FILL;
      S_CP_RD:    state_nxt = S_CP_WR;
      S_CP_WR:    state_nxt = last_word ? S_RESP : S_CP_RD;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Write enable is masked by rst so a reset cycle never commits a word.
  always_comb begin
    req_ready  = (state == S_IDLE);
    busy       = (state != S_IDLE);
    resp_valid = (state == S_RESP);
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_in     = '0;
    case (state)
      S_RD:    mem_addr = addr_q;
      S_WR: begin
        mem_addr = addr_q;
        mem_in   = data_q;
        mem_we   = !rst;
      end
      S_FILL: begin
        mem_addr = addr_q + cnt_x;
        mem_in   = data_q;
        mem_we   = !rst;
      end
      S_CP_RD: mem_addr = addr_q + cnt_x;
      S_CP_WR: begin
        mem_addr = data_q[ADDR_W-1:0] + cnt_x;
        mem_in   = hold;
        mem_we   = !rst;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      data_q    <= '0;
      len_q     <= '0;
      cnt       <= '0;
      hold      <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= req_addr;
        data_q    <= req_data;
        len_q     <= req_len;
        cnt       <= '0;
        resp_data <= '0;
        resp_err  <= !range_ok;
      end
      if (state == S_RD)    resp_data <= mem_out;
      if (state == S_CP_RD) hold <= mem_out;
      if (state == S_FILL || state == S_CP_WR) cnt <= cnt + 9'd1;
    end
  end
endmodule
`default_nettype wire
